// File: rtl/wb_drain_axi.sv
// Drains a write-buffer FIFO onto an AXI write channel, one single-beat
// write at a time. The head entry is captured in IDLE, AW and W are
// presented together and handshaken independently, the B response is
// awaited, and the entry is then popped.
module wb_drain_axi #(
    parameter int unsigned DATA_WIDTH = 71,
    parameter logic [3:0]  AXI_ID     = 4'd1
) (
    input  logic                  clk,
    input  logic                  reset,

    // write-buffer FIFO side
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_complete,

    // AXI write address channel
    output logic [3:0]            awid,
    output logic [31:0]           awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,

    // AXI write data channel
    output logic [3:0]            wid,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,

    // AXI write response channel
    input  logic [3:0]            bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,

    // status
    output logic                  busy,
    output logic                  bus_err,
    output logic [15:0]           wr_count
);

    // FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_POP  = 2'd3;

    // FIFO entry field positions
    localparam int unsigned ADDR_MSB = 70;
    localparam int unsigned ADDR_LSB = 39;
    localparam int unsigned DATA_MSB = 38;
    localparam int unsigned DATA_LSB = 7;
    localparam int unsigned STRB_MSB = 6;
    localparam int unsigned STRB_LSB = 3;
    localparam int unsigned SIZE_MSB = 2;
    localparam int unsigned SIZE_LSB = 0;

    logic [1:0]  state_q,     state_d;
    logic        awvalid_q,   awvalid_d;
    logic        wvalid_q,    wvalid_d;
    logic        aw_done_q,   aw_done_d;
    logic        w_done_q,    w_done_d;
    logic        bus_err_q,   bus_err_d;
    logic [15:0] wr_count_q,  wr_count_d;

    logic [31:0] addr_q,      addr_d;
    logic [31:0] data_q,      data_d;
    logic [3:0]  strb_q,      strb_d;
    logic [2:0]  size_q,      size_d;

    logic        capture;
    logic        aw_hs;
    logic        w_hs;
    logic        aw_fin;
    logic        w_fin;
    logic        b_accept;

    assign aw_hs    = awvalid_q & awready;
    assign w_hs     = wvalid_q & wready;
    // a channel counts as finished if it completed earlier or completes now,
    // so simultaneous AW/W handshakes still leave SEND in one cycle
    assign aw_fin   = aw_done_q | aw_hs;
    assign w_fin    = w_done_q | w_hs;
    assign b_accept = (state_q == ST_RESP) && bvalid && (bid == AXI_ID);
    assign capture  = (state_q == ST_IDLE) && !fifo_empty;

    // next-state logic for the control FSM, handshake tracking and status
    always_comb begin
        state_d    = state_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        bus_err_d  = bus_err_q;
        wr_count_d = wr_count_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_fin && w_fin) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (b_accept) begin
                    if (bresp != 2'b00) begin
                        bus_err_d = 1'b1;
                    end
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                wr_count_d = wr_count_q + 16'd1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // payload next-state: fifo_rdata is only looked at while IDLE
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        strb_d = strb_q;
        size_d = size_q;
        if (capture) begin
            addr_d = fifo_rdata[ADDR_MSB:ADDR_LSB];
            data_d = fifo_rdata[DATA_MSB:DATA_LSB];
            strb_d = fifo_rdata[STRB_MSB:STRB_LSB];
            size_d = fifo_rdata[SIZE_MSB:SIZE_LSB];
        end
    end

    // control and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            bus_err_q  <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            bus_err_q  <= bus_err_d;
            wr_count_q <= wr_count_d;
        end
    end

    // captured payload, left unreset since it is only used after a capture
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        strb_q <= strb_d;
        size_q <= size_d;
    end

    // write address channel
    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = size_q;
    assign awburst = 2'b01;
    assign awvalid = awvalid_q;

    // write data channel
    assign wid     = AXI_ID;
    assign wdata   = data_q;
    assign wstrb   = strb_q;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_q;

    // response channel and status
    assign bready        = (state_q == ST_RESP);
    assign fifo_complete = (state_q == ST_POP);
    assign busy          = (state_q != ST_IDLE);
    assign bus_err       = bus_err_q;
    assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_wb_drain_axi.sv
// Scoreboard bench for wb_drain_axi: a FIFO model, a configurable AXI
// slave, directed writes with hand-computed expectations, and a monitor
// that checks every handshake and every pop against the expected queue.
module tb_wb_drain_axi;

    localparam logic [3:0] ID = 4'd1;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic [70:0] fifo_rdata;
    logic        fifo_complete;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        busy;
    logic        bus_err;
    logic [15:0] wr_count;

    always #5 clk = ~clk;

    wb_drain_axi #(.DATA_WIDTH(71), .AXI_ID(4'd1)) dut (
        .clk(clk), .reset(reset),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_complete(fifo_complete),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .busy(busy), .bus_err(bus_err), .wr_count(wr_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  size;
        int unsigned exp_cyc;
        int unsigned n_aw;
        int unsigned n_w;
        int unsigned n_b;
        logic        exp_err;
        logic [15:0] cnt_before;
    } exp_t;

    exp_t        exp_q[$];
    logic [70:0] fifo_q[$];
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;
    int unsigned model_cnt = 0;

    // slave and FIFO configuration
    int unsigned aw_delay = 0;
    int unsigned w_delay = 0;
    int unsigned b_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic        bad_bid = 1'b0;
    logic        scramble = 1'b0;
    logic        pop_pend = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // FIFO model: pops requested by the monitor, head (or junk while busy) driven
    initial begin
        fifo_empty = 1'b1;
        fifo_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (pop_pend) begin
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
                pop_pend = 1'b0;
            end
            fifo_empty = (fifo_q.size() == 0);
            if (fifo_q.size() == 0) fifo_rdata = '0;
            else if (scramble && busy) fifo_rdata = ~fifo_q[0];
            else fifo_rdata = fifo_q[0];
        end
    end

    // AXI slave: ready after a programmable wait, B after a programmable wait
    initial begin
        int unsigned aw_n;
        int unsigned w_n;
        int unsigned b_n;
        aw_n = 0; w_n = 0; b_n = 0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
        forever begin
            @(negedge clk);
            if (awvalid) begin
                if (aw_n >= aw_delay) awready = 1'b1;
                else begin awready = 1'b0; aw_n++; end
            end else begin
                awready = 1'b0; aw_n = 0;
            end
            if (wvalid) begin
                if (w_n >= w_delay) wready = 1'b1;
                else begin wready = 1'b0; w_n++; end
            end else begin
                wready = 1'b0; w_n = 0;
            end
            if (bready) begin
                if (b_n >= b_delay) begin
                    bvalid = 1'b1; bid = ID; bresp = bresp_cfg;
                end else begin
                    bvalid = bad_bid; bid = 4'd7; bresp = 2'b10; b_n++;
                end
            end else begin
                bvalid = 1'b0; bid = '0; bresp = '0; b_n = 0;
            end
        end
    end

    // monitor: protocol stability, handshake payloads, pop accounting
    initial begin
        exp_t        e;
        logic        p_awv;
        logic        p_awhs;
        logic        p_wv;
        logic        p_whs;
        logic [34:0] p_aw;
        logic [35:0] p_w;
        int unsigned n_aw;
        int unsigned n_w;
        int unsigned n_b;
        p_awv = 1'b0; p_awhs = 1'b0; p_wv = 1'b0; p_whs = 1'b0;
        p_aw = '0; p_w = '0;
        n_aw = 0; n_w = 0; n_b = 0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                p_awv = 1'b0; p_wv = 1'b0; p_awhs = 1'b0; p_whs = 1'b0;
                n_aw = 0; n_w = 0; n_b = 0;
                continue;
            end
            if (p_awv && !p_awhs)
                chk("aw_hold", 64'({awvalid, awsize, awaddr}), 64'({1'b1, p_aw}));
            if (p_wv && !p_whs)
                chk("w_hold", 64'({wvalid, wstrb, wdata}), 64'({1'b1, p_w}));
            if (awvalid) n_aw++;
            if (wvalid) n_w++;
            if (bready) n_b++;
            if (awvalid && awready) begin
                chk("aw_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    chk("awaddr", 64'(awaddr), 64'(exp_q[0].addr));
                    chk("awsize", 64'(awsize), 64'(exp_q[0].size));
                    chk("aw_fixed", 64'({awid, awlen, awburst}), 64'({ID, 8'd0, 2'b01}));
                end
            end
            if (wvalid && wready) begin
                chk("w_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    chk("wdata", 64'(wdata), 64'(exp_q[0].data));
                    chk("wstrb", 64'(wstrb), 64'(exp_q[0].strb));
                    chk("w_fixed", 64'({wid, wlast}), 64'({ID, 1'b1}));
                end
            end
            if (fifo_complete) begin
                chk("pop_nonempty", 64'(fifo_empty), 64'(0));
                chk("pop_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pop_cycle", 64'(cyc), 64'(e.exp_cyc));
                    chk("awvalid_cycles", 64'(n_aw), 64'(e.n_aw));
                    chk("wvalid_cycles", 64'(n_w), 64'(e.n_w));
                    chk("bready_cycles", 64'(n_b), 64'(e.n_b));
                    chk("pop_bus_err", 64'(bus_err), 64'(e.exp_err));
                    chk("pop_wr_count", 64'(wr_count), 64'(e.cnt_before));
                end
                n_aw = 0; n_w = 0; n_b = 0;
                pop_pend = 1'b1;
            end
            p_awv = awvalid; p_awhs = awvalid && awready; p_aw = {awsize, awaddr};
            p_wv = wvalid; p_whs = wvalid && wready; p_w = {wstrb, wdata};
        end
    end

    // queue one FIFO entry and its expected outcome; call at posedge+1
    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] z, input int unsigned lat, input int unsigned naw,
                        input int unsigned nw, input int unsigned nb, input logic err_after);
        exp_t e;
        fifo_q.push_back({a, d, s, z});
        e.addr = a; e.data = d; e.strb = s; e.size = z;
        e.exp_cyc = cyc + lat;
        e.n_aw = naw; e.n_w = nw; e.n_b = nb;
        e.exp_err = err_after;
        e.cnt_before = 16'(model_cnt);
        model_cnt++;
        exp_q.push_back(e);
    endtask

    task automatic cfg(input int unsigned awd, input int unsigned wd, input int unsigned bd,
                       input logic [1:0] br, input logic bb);
        aw_delay = awd; w_delay = wd; b_delay = bd; bresp_cfg = br; bad_bid = bb;
    endtask

    task automatic wait_idle(input int unsigned lim);
        int unsigned n;
        n = 0;
        while ((fifo_q.size() != 0 || busy || exp_q.size() != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        #2;
        chk("idle_reached", 64'(fifo_q.size() == 0 && !busy && exp_q.size() == 0), 64'(1));
    endtask

    task automatic next_slot();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned n;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valids", 64'({awvalid, wvalid, bready}), 64'(0));
        chk("rst_pop_busy", 64'({fifo_complete, busy}), 64'(0));
        chk("rst_bus_err", 64'(bus_err), 64'(0));
        chk("rst_wr_count", 64'(wr_count), 64'(0));
        next_slot();
        reset = 1'b0;

        // single write, zero-wait slave
        cfg(0, 0, 0, 2'b00, 1'b0);
        next_slot();
        push(32'h1FC0_0010, 32'hDEAD_BEEF, 4'hF, 3'd2, 3, 1, 1, 1, 1'b0);
        wait_idle(40);
        chk("t1_wr_count", 64'(wr_count), 64'(1));

        // AW first, W held off 5 cycles
        cfg(0, 5, 0, 2'b00, 1'b0);
        next_slot();
        push(32'h0000_1000, 32'h1234_5678, 4'h3, 3'd1, 8, 1, 6, 1, 1'b0);
        wait_idle(40);

        // W first, AW held off 3 cycles, B stalled 3 cycles
        cfg(3, 0, 3, 2'b00, 1'b0);
        next_slot();
        push(32'h8000_0004, 32'hA5A5_5A5A, 4'b1001, 3'd0, 9, 4, 1, 4, 1'b0);
        wait_idle(40);

        // foreign-ID error responses ahead of the real one must be ignored
        cfg(0, 0, 2, 2'b00, 1'b1);
        next_slot();
        push(32'h0000_0020, 32'h0BAD_F00D, 4'hC, 3'd2, 5, 1, 1, 3, 1'b0);
        wait_idle(40);
        chk("t3b_bus_err", 64'(bus_err), 64'(0));

        // SLVERR then OKAY: bus_err sticks, counting continues
        cfg(0, 0, 0, 2'b10, 1'b0);
        next_slot();
        push(32'h0000_0040, 32'h1111_2222, 4'hF, 3'd2, 3, 1, 1, 1, 1'b1);
        wait_idle(40);
        cfg(0, 0, 0, 2'b00, 1'b0);
        next_slot();
        push(32'h0000_0044, 32'h3333_4444, 4'hF, 3'd2, 3, 1, 1, 1, 1'b1);
        wait_idle(40);
        chk("t4_bus_err", 64'(bus_err), 64'(1));
        chk("t4_wr_count", 64'(wr_count), 64'(6));

        // three queued entries; FIFO output is junk whenever the block is busy
        scramble = 1'b1;
        next_slot();
        push(32'h0000_0100, 32'hCAFE_0001, 4'h1, 3'd0, 3, 1, 1, 1, 1'b1);
        push(32'h0000_0104, 32'hCAFE_0002, 4'h2, 3'd0, 7, 1, 1, 1, 1'b1);
        push(32'h0000_0108, 32'hCAFE_0003, 4'h4, 3'd0, 11, 1, 1, 1, 1'b1);
        wait_idle(60);
        scramble = 1'b0;
        chk("t5_wr_count", 64'(wr_count), 64'(9));

        // reset while waiting in RESP
        cfg(0, 0, 20, 2'b00, 1'b0);
        next_slot();
        push(32'h0000_0200, 32'h5555_AAAA, 4'hF, 3'd2, 0, 0, 0, 0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!bready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_resp_reached", 64'(bready), 64'(1));
        next_slot();
        reset = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        model_cnt = 0;
        next_slot();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_valids", 64'({awvalid, wvalid, bready}), 64'(0));
        chk("t6_pop_busy", 64'({fifo_complete, busy}), 64'(0));
        chk("t6_wr_count", 64'(wr_count), 64'(0));
        chk("t6_bus_err", 64'(bus_err), 64'(0));
        @(negedge clk);
        chk("t6_no_pop", 64'(fifo_complete), 64'(0));

        // recovery write after reset
        cfg(0, 0, 0, 2'b00, 1'b0);
        next_slot();
        push(32'h1FC0_0080, 32'h0F0F_F0F0, 4'hF, 3'd2, 3, 1, 1, 1, 1'b0);
        wait_idle(40);
        chk("t7_wr_count", 64'(wr_count), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
